// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam int DIGIT_W    = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_ADD    = 3;

  // Decimal digits needed for 2^bin_w - 1. 2^n is never a power of ten for n >= 1,
  // so its digit count equals floor(n*log10(2)) + 1.
  function automatic int min_digits(input int bin_w);
    return (bin_w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble adjust cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= DIGIT_W'(ADJ_THRESH)) d_o = d_i + DIGIT_W'(ADJ_ADD);
  end

endmodule

// File: rtl/bcd_seq_convert.sv
// Iterative binary-to-BCD converter, one input bit per clock, valid/ready on both sides.
// Optional BCD_SEQ_SKIP_LZ_EN: skip leading zeros of the input to shorten the conversion.
module bcd_seq_convert
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIN_W-1:0]          in_bin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                      busy
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SR_W  = BCD_W + BIN_W;

  if (BIN_W < 1) begin : g_bad_bin_w
    $error("bcd_seq_convert: BIN_W must be >= 1");
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
    $error("bcd_seq_convert: DIGITS too small for BIN_W");
  end

  state_e                           state_q, state_d;
  logic [DIGITS-1:0][DIGIT_W-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [BIN_W-1:0]                 bin_q, bin_d, bin_load;
  logic [CNT_W-1:0]                 cnt_q, cnt_d, cnt_load;
  logic [SR_W-1:0]                  sr_next;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (bcd_q[g]),
      .d_o (bcd_adj[g])
    );
  end

`ifdef BCD_SEQ_SKIP_LZ_EN
  logic [CNT_W-1:0] lz;
  logic             lz_found;

  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = BIN_W - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (in_bin[i]) lz_found = 1'b1;
        else           lz       = lz + CNT_W'(1);
      end
    end
  end

  // Leading zeros contribute nothing to the BCD value, so they are shifted out up front.
  assign bin_load = in_bin << lz;
  assign cnt_load = CNT_W'(BIN_W) - lz;
`else
  assign bin_load = in_bin;
  assign cnt_load = CNT_W'(BIN_W);
`endif

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_bcd   = bcd_q;

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    // Adjust-then-shift; the top BCD bit falls off, which the DIGITS check makes unreachable.
    sr_next = {bcd_adj, bin_q} << 1;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          bin_d   = bin_load;
          bcd_d   = '0;
          cnt_d   = cnt_load;
          state_d = (cnt_load == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = sr_next;
        cnt_d          = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bcd_seq_convert.sv
// Directed bench for bcd_seq_convert: 8-bit default instance plus a 12-bit/4-digit instance.
module tb_bcd_seq_convert;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  in_bin;
  logic [11:0] out_bcd;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [11:0] in_bin2;
  logic [15:0] out_bcd2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_seq_convert #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .busy(busy)
  );

  bcd_seq_convert #(.BIN_W(12), .DIGITS(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_bin(in_bin2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_bcd(out_bcd2), .busy(busy2)
  );

  // Edge count from accept to the edge at which out_valid is first seen high.
  function automatic int lat8(input logic [7:0] v);
`ifdef BCD_SEQ_SKIP_LZ_EN
    int p;
    if (v == 8'd0) return 1;
    p = 0;
    for (int i = 0; i < 8; i++) if (v[i]) p = i;
    return p + 2;
`else
    return (v == 8'd0) ? 9 : 9;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] v);
    int n = 0;
    in_bin   = v;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (out_bcd !== 12'h000) begin errors++; $display("FAIL rst_out_bcd got %h want 000", out_bcd); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL rst_in_ready2 got %b want 0", in_ready2); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    accept(8'd243);
    in_bin = 8'hAA;  // must not affect the captured value
    wait_valid(lat);
    checks++; if (lat !== lat8(8'd243)) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, lat8(8'd243)); end
    checks++; if (out_bcd !== 12'h243) begin errors++; $display("FAIL basic_bcd got %h want 243", out_bcd); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_done_flags busy=%b in_ready=%b want 1/0", busy, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b want 1", in_ready); end
  endtask

  task automatic test_edges();
    int lat;
    out_ready = 1'b1;
    accept(8'd5);
    wait_valid(lat);
    checks++; if (lat !== lat8(8'd5)) begin errors++; $display("FAIL five_latency got %0d want %0d", lat, lat8(8'd5)); end
    checks++; if (out_bcd !== 12'h005) begin errors++; $display("FAIL five_bcd got %h want 005", out_bcd); end
    tick();
    accept(8'd0);
    wait_valid(lat);
    checks++; if (lat !== lat8(8'd0)) begin errors++; $display("FAIL zero_latency got %0d want %0d", lat, lat8(8'd0)); end
    checks++; if (out_bcd !== 12'h000) begin errors++; $display("FAIL zero_bcd got %h want 000", out_bcd); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vals [3];
    logic [11:0] exps [3];
    logic [11:0] got  [3];
    int          acc  [3];
    int idx = 0, ngot = 0, cyc = 0;
    logic hs_in, hs_out;
    logic [11:0] obcd;
    vals[0] = 8'd0;    vals[1] = 8'd255;  vals[2] = 8'd99;
    exps[0] = 12'h000; exps[1] = 12'h255; exps[2] = 12'h099;
    for (int i = 0; i < 3; i++) begin got[i] = '0; acc[i] = 0; end
    out_ready = 1'b1;
    in_bin    = vals[0];
    in_valid  = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      obcd   = out_bcd;
      tick();
      cyc++;
      if (hs_in) begin
        if (idx < 3) acc[idx] = cyc;
        idx++;
        if (idx < 3) in_bin = vals[idx];
        else         in_valid = 1'b0;
      end
      if (hs_out) begin
        if (ngot < 3) got[ngot] = obcd;
        ngot++;
      end
    end
    in_valid = 1'b0;
    checks++; if (idx !== 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", idx); end
    checks++; if (ngot !== 3) begin errors++; $display("FAIL b2b_results got %0d want 3", ngot); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got[i] !== exps[i]) begin errors++; $display("FAIL b2b_bcd%0d got %h want %h", i, got[i], exps[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (acc[i+1] - acc[i] !== lat8(vals[i]) + 1) begin
        errors++; $display("FAIL b2b_spacing%0d got %0d want %0d", i, acc[i+1] - acc[i], lat8(vals[i]) + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    accept(8'd128);
    wait_valid(lat);
    checks++; if (lat !== lat8(8'd128)) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, lat8(8'd128)); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || out_bcd !== 12'h128) begin
        errors++; $display("FAIL bp_hold%0d valid=%b busy=%b in_ready=%b bcd=%h want 1/1/0/128", i, out_valid, busy, in_ready, out_bcd);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release valid=%b busy=%b in_ready=%b want 0/0/1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen = 1'b0;
    out_ready = 1'b1;
    accept(8'd200);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_bcd !== 12'h000) begin
      errors++; $display("FAIL midrst_state valid=%b busy=%b bcd=%h want 0/0/000", out_valid, busy, out_bcd);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_result got %b want 0", seen); end
    accept(8'd37);
    wait_valid(lat);
    checks++; if (lat !== lat8(8'd37)) begin errors++; $display("FAIL midrst_latency got %0d want %0d", lat, lat8(8'd37)); end
    checks++; if (out_bcd !== 12'h037) begin errors++; $display("FAIL midrst_bcd got %h want 037", out_bcd); end
    tick();
  endtask

  task automatic test_wide();
    int lat = 1;
    out_ready2 = 1'b1;
    in_bin2    = 12'd4095;
    in_valid2  = 1'b1;
    checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL wide_in_ready got %b want 1", in_ready2); end
    tick();
    in_valid2 = 1'b0;
    while (!out_valid2 && lat < 60) begin
      tick();
      lat++;
    end
    checks++; if (lat !== 13) begin errors++; $display("FAIL wide_latency got %0d want 13", lat); end
    checks++; if (out_bcd2 !== 16'h4095) begin errors++; $display("FAIL wide_bcd got %h want 4095", out_bcd2); end
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_bin     = '0;
    out_ready  = 1'b0;
    in_valid2  = 1'b0;
    in_bin2    = '0;
    out_ready2 = 1'b0;
    test_reset();
    test_basic();
    test_edges();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_seq_convert.md
Name: bcd_seq_convert

Overview:
- Iterative, multi-cycle binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm.
- Processes one input bit per clock, so a single adjust stage is reused instead of unrolling the whole conversion.
- Uses valid/ready handshakes on input and output, so it sits between a binary producer (counter, ADC, register file) and a display/UART formatter.
- One conversion in flight at a time.

Parameters:
- BIN_W, 8, width of the binary input in bits (>=1).
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents in_bin.
- in_ready  output  1  converter can accept; high only in IDLE and never while rst is high.
- in_bin  input  BIN_W  unsigned binary value; sampled only on in_valid && in_ready.
- out_valid  output  1  out_bcd holds a completed result.
- out_ready  input  1  consumer accepts result.
- out_bcd  output  4*DIGITS  packed BCD, digit 0 in [3:0]; stable while out_valid is high.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset values (at the first edge with rst high): state=IDLE, out_valid=0, out_bcd=0, busy=0, shift count=0. in_ready is 0 while rst is high and 1 the cycle after rst deasserts.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge E0: load the binary shift register with in_bin, clear the BCD register, set count=BIN_W, go to SHIFT.
- SHIFT, one iteration per cycle:
  - Each BCD digit >4 gets +3 (4-bit result, no carry out of the digit).
  - Then {bcd, bin} shifts left by 1; the MSB of bin enters bit 0 of digit 0.
  - count decrements. When count reaches 1 at the start of a cycle, that cycle does the final iteration and the FSM goes to DONE.
  - Exactly BIN_W SHIFT cycles; no adjustment occurs after the last shift.
- DONE:
  - out_valid=1 and out_bcd = final BCD register.
  - On out_ready go to IDLE; out_valid drops at the same edge.
- Latency: out_valid first high at edge E0+BIN_W+1 (9 cycles for BIN_W=8). The one-cycle accept-to-first-shift gap is part of the contract.
- Throughput: one conversion per BIN_W+2 cycles minimum; a new input cannot be accepted in the same cycle a result is consumed.
- Back-pressure: DONE holds indefinitely; out_bcd, out_valid and busy do not change; in_ready stays 0.
- in_valid while busy: ignored, not latched. The producer must hold its data.
- in_bin changes during SHIFT: no effect; the value was captured at accept.
- Reset mid-SHIFT or mid-DONE: the conversion is discarded, all outputs go to reset values, and no partial result is ever presented.
- Widths: the internal BCD register is 4*DIGITS bits. Shifted-out BCD MSBs are dropped; this is unreachable when the DIGITS constraint holds.

Optional Feature:
- Macro: BCD_SEQ_SKIP_LZ_EN.
- Defined:
  - At accept, a leading-zero count of in_bin is computed. The binary register is pre-shifted left by that count, and count is loaded with BIN_W - lz.
  - in_bin=0 loads count=0, goes directly IDLE->DONE, and gives out_valid at E0+1 with out_bcd=0.
  - Otherwise latency is (BIN_W - lz)+1 cycles. Results are identical to the feature-off build.
- Undefined: fixed BIN_W+1 latency; no leading-zero logic is synthesized.

Decomposition:
- Package bcd_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Constants: DIGIT_W=4, ADJ_THRESH=5, ADJ_ADD=3.
  - Function min_digits(bin_w) for the parameter check.
- Sub-module bcd_digit_adj: combinational, 4-bit in/out, adds 3 when the input is >=5. Instantiated DIGITS times in a generate loop.
- FSM and shift datapath stay in bcd_seq_convert.

Test Plan:
- in_bin=8'd243 with out_ready=1 -> out_bcd=12'h243, out_valid at E0+9 for exactly 1 cycle, in_ready high the next cycle.
- in_bin=8'd0, then 8'd255, then 8'd99 back-to-back with in_valid held high -> 12'h000, 12'h255, 12'h099. Accepts are spaced by BIN_W+2 cycles; no input is dropped or duplicated.
- in_bin=8'd128, out_ready low for 6 cycles after out_valid -> out_bcd=12'h128 stable; busy=1, in_ready=0 throughout. Release out_ready -> IDLE next edge.
- Accept 8'd200, assert rst at the 4th SHIFT cycle -> out_valid never rises. Next accepted 8'd37 yields 12'h037 with nominal latency.
- BIN_W=12, DIGITS=4, in_bin=4095 -> 16'h4095 at E0+13.
- With BCD_SEQ_SKIP_LZ_EN:
  - in_bin=8'd5 -> 12'h005 at E0+4.
  - in_bin=8'd0 -> 12'h000 at E0+1.
  - in_bin=8'd243 -> 12'h243 at E0+9.
